// File: rtl/axi4_master_pkg.sv
// Shared types and helpers for the single-burst AXI4 initiator.
// Holds the FSM state encoding, AXI response/burst codes and the 4KB boundary test.
package axi4_master_pkg;

  typedef enum logic [2:0] {
    IDLE,
    W_ADDR,
    W_DATA,
    W_RESP,
    R_ADDR,
    R_DATA,
    REJECT
  } state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] BURST_INCR  = 2'b01;

  // A burst may end exactly on the 4KB boundary but not run past it.
  function automatic logic crosses_4k(input logic [11:0] addr_lo,
                                      input logic [15:0] len,
                                      input logic [15:0] bytes);
    logic [31:0] end_b;
    end_b = 32'(addr_lo) + (32'(len) + 32'd1) * 32'(bytes);
    return end_b > 32'd4096;
  endfunction

  function automatic logic [1:0] worst_resp(input logic [1:0] a, input logic [1:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/axi4_beat_cnt.sv
// Beat counter shared by the W and R paths: cleared on command accept, bumped per data handshake.
// last_o flags the beat whose index equals the programmed AxLEN.
module axi4_beat_cnt #(
  parameter int LEN_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             inc_i,
  input  logic [LEN_W-1:0] len_i,
  output logic [LEN_W-1:0] cnt_o,
  output logic             last_o
);

  logic [LEN_W-1:0] cnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (inc_i) begin
      cnt_q <= cnt_q + LEN_W'(1);
    end
  end

  assign cnt_o  = cnt_q;
  assign last_o = (cnt_q == len_i);

endmodule

// File: rtl/axi4_burst_master.sv
// AXI4 initiator running one INCR burst at a time from a simple command port.
// Bus-facing valids/readies decode straight from the state register so reset drops them at once.
module axi4_burst_master
  import axi4_master_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 8
) (
  input  logic                aclk_i,
  input  logic                areset_i,
  input  logic                cmd_valid_i,
  output logic                cmd_ready_o,
  input  logic                cmd_write_i,
  input  logic [ADDR_W-1:0]   cmd_addr_i,
  input  logic [LEN_W-1:0]    cmd_len_i,
  input  logic [DATA_W-1:0]   wr_data_i,
  input  logic                wr_valid_i,
  output logic                wr_ready_o,
  output logic [DATA_W-1:0]   rd_data_o,
  output logic                rd_valid_o,
  output logic                rd_last_o,
  input  logic                rd_ready_i,
  output logic                done_o,
  output logic [1:0]          done_resp_o,
  output logic                done_err_o,
  output logic [ADDR_W-1:0]   awaddr_o,
  output logic [LEN_W-1:0]    awlen_o,
  output logic [2:0]          awsize_o,
  output logic [1:0]          awburst_o,
  output logic                awvalid_o,
  input  logic                awready_i,
  output logic [DATA_W-1:0]   wdata_o,
  output logic [DATA_W/8-1:0] wstrb_o,
  output logic                wlast_o,
  output logic                wvalid_o,
  input  logic                wready_i,
  input  logic [1:0]          bresp_i,
  input  logic                bvalid_i,
  output logic                bready_o,
  output logic [ADDR_W-1:0]   araddr_o,
  output logic [LEN_W-1:0]    arlen_o,
  output logic [2:0]          arsize_o,
  output logic [1:0]          arburst_o,
  output logic                arvalid_o,
  input  logic                arready_i,
  input  logic [DATA_W-1:0]   rdata_i,
  input  logic [1:0]          rresp_i,
  input  logic                rlast_i,
  input  logic                rvalid_i,
  output logic                rready_o
);

  localparam int         BYTES = DATA_W / 8;
  localparam logic [2:0] SIZE  = 3'($clog2(BYTES));

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               done_q, done_d;
  logic [1:0]         resp_q, resp_d;
  logic               err_q, err_d;
  logic               cnt_clr, cnt_inc, cnt_last;
  logic [LEN_W-1:0]   cnt_val;
  logic [ADDR_W-1:0]  addr_aligned;

  assign addr_aligned = cmd_addr_i & ~ADDR_W'(BYTES - 1);
  assign cmd_ready_o  = (state_q == IDLE) && !areset_i;

  axi4_beat_cnt #(.LEN_W(LEN_W)) u_beat_cnt (
    .clk_i  (aclk_i),
    .rst_i  (areset_i),
    .clr_i  (cnt_clr),
    .inc_i  (cnt_inc),
    .len_i  (len_q),
    .cnt_o  (cnt_val),
    .last_o (cnt_last)
  );

  always_ff @(posedge aclk_i or posedge areset_i) begin
    if (areset_i) begin
      state_q <= IDLE;
      addr_q  <= '0;
      len_q   <= '0;
      done_q  <= 1'b0;
      resp_q  <= RESP_OKAY;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      done_q  <= done_d;
      resp_q  <= resp_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    len_d      = len_q;
    done_d     = 1'b0;
    resp_d     = resp_q;
    err_d      = err_q;
    cnt_clr    = 1'b0;
    cnt_inc    = 1'b0;
    awvalid_o  = 1'b0;
    wvalid_o   = 1'b0;
    wr_ready_o = 1'b0;
    bready_o   = 1'b0;
    arvalid_o  = 1'b0;
    rready_o   = 1'b0;
    rd_valid_o = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cmd_valid_i && cmd_ready_o) begin
          addr_d  = addr_aligned;
          len_d   = cmd_len_i;
          resp_d  = RESP_OKAY;
          err_d   = 1'b0;
          cnt_clr = 1'b1;
          if (crosses_4k(addr_aligned[11:0], 16'(cmd_len_i), 16'(BYTES))) begin
            state_d = REJECT;
          end else begin
            state_d = cmd_write_i ? W_ADDR : R_ADDR;
          end
        end
      end
      W_ADDR: begin
        awvalid_o = 1'b1;
        if (awready_i) state_d = W_DATA;
      end
      W_DATA: begin
        wvalid_o   = wr_valid_i;
        wr_ready_o = wready_i;
        if (wr_valid_i && wready_i) begin
          cnt_inc = 1'b1;
          if (cnt_last) state_d = W_RESP;
        end
      end
      W_RESP: begin
        bready_o = 1'b1;
        if (bvalid_i) begin
          done_d  = 1'b1;
          resp_d  = bresp_i;
          state_d = IDLE;
        end
      end
      R_ADDR: begin
        arvalid_o = 1'b1;
        if (arready_i) state_d = R_DATA;
      end
      R_DATA: begin
        rd_valid_o = rvalid_i;
        rready_o   = rd_ready_i;
        if (rvalid_i && rd_ready_i) begin
          cnt_inc = 1'b1;
          resp_d  = worst_resp(resp_q, rresp_i);
          // RLAST alone closes the burst; a count disagreement is only reported.
          if (rlast_i) begin
            done_d  = 1'b1;
            err_d   = !cnt_last;
            state_d = IDLE;
          end
        end
      end
      REJECT: begin
        done_d  = 1'b1;
        resp_d  = RESP_SLVERR;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign awaddr_o    = addr_q;
  assign awlen_o     = len_q;
  assign awsize_o    = SIZE;
  assign awburst_o   = BURST_INCR;
  assign araddr_o    = addr_q;
  assign arlen_o     = len_q;
  assign arsize_o    = SIZE;
  assign arburst_o   = BURST_INCR;
  assign wdata_o     = wr_data_i;
  assign wstrb_o     = '1;
  assign wlast_o     = (state_q == W_DATA) && cnt_last;
  assign rd_data_o   = rdata_i;
  assign rd_last_o   = (state_q == R_DATA) && rlast_i;
  assign done_o      = done_q;
  assign done_resp_o = resp_q;
  assign done_err_o  = err_q;

endmodule

// File: tb/tb_axi4_burst_master.sv
// Directed bench for axi4_burst_master: drives a scripted AXI slave and compares against hand-computed values.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
module tb_axi4_burst_master;

  logic        clk = 1'b0;
  logic        areset;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr;
  logic [7:0]  cmd_len;
  logic [31:0] wr_data;
  logic        wr_valid, wr_ready;
  logic [31:0] rd_data;
  logic        rd_valid, rd_last, rd_ready;
  logic        done, done_err;
  logic [1:0]  done_resp;
  logic [31:0] awaddr, araddr, wdata, rdata;
  logic [7:0]  awlen, arlen;
  logic [2:0]  awsize, arsize;
  logic [1:0]  awburst, arburst, bresp, rresp;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rlast, rvalid, rready;
  logic [3:0]  wstrb;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  axi4_burst_master dut (
    .aclk_i(clk), .areset_i(areset),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_write_i(cmd_write),
    .cmd_addr_i(cmd_addr), .cmd_len_i(cmd_len),
    .wr_data_i(wr_data), .wr_valid_i(wr_valid), .wr_ready_o(wr_ready),
    .rd_data_o(rd_data), .rd_valid_o(rd_valid), .rd_last_o(rd_last), .rd_ready_i(rd_ready),
    .done_o(done), .done_resp_o(done_resp), .done_err_o(done_err),
    .awaddr_o(awaddr), .awlen_o(awlen), .awsize_o(awsize), .awburst_o(awburst),
    .awvalid_o(awvalid), .awready_i(awready),
    .wdata_o(wdata), .wstrb_o(wstrb), .wlast_o(wlast), .wvalid_o(wvalid), .wready_i(wready),
    .bresp_i(bresp), .bvalid_i(bvalid), .bready_o(bready),
    .araddr_o(araddr), .arlen_o(arlen), .arsize_o(arsize), .arburst_o(arburst),
    .arvalid_o(arvalid), .arready_i(arready),
    .rdata_i(rdata), .rresp_i(rresp), .rlast_i(rlast), .rvalid_i(rvalid), .rready_o(rready)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send_cmd(input logic wr, input logic [31:0] addr, input logic [7:0] len);
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_len = len;
    @(negedge clk);
    check("cmd_ready_idle", cmd_ready, 1'b1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  // abort_beat >= 0 pulls reset while that W beat is being offered.
  task automatic do_write(input logic [31:0] addr, input logic [7:0] len, input int aw_wait,
                          input bit w_tog, input logic [1:0] b_resp, input logic [31:0] dbase,
                          input int abort_beat);
    int beat;
    int cyc;
    logic hs;
    wr_valid = 1'b1;
    wr_data  = dbase;
    send_cmd(1'b1, addr, len);
    @(negedge clk);
    check("awvalid_first", awvalid, 1'b1);
    check("awaddr", awaddr, addr & ~32'h3);
    check("awlen", awlen, len);
    check("awsize", awsize, 3'd2);
    check("awburst", awburst, 2'b01);
    check("wvalid_before_aw", wvalid, 1'b0);
    for (int i = 0; i < aw_wait; i++) begin
      @(negedge clk);
      check("awvalid_hold", awvalid, 1'b1);
      check("awaddr_hold", awaddr, addr & ~32'h3);
      check("wvalid_during_aw", wvalid, 1'b0);
    end
    awready = 1'b1;
    @(posedge clk); #1;
    awready = 1'b0;
    beat = 0;
    cyc  = 0;
    while (beat <= int'(len) && cyc < 100) begin
      wready   = w_tog ? cyc[0] : 1'b1;
      wr_valid = 1'b1;
      wr_data  = dbase + 32'(beat);
      @(negedge clk);
      check("wvalid", wvalid, 1'b1);
      check("wdata", wdata, dbase + 32'(beat));
      check("wlast", wlast, beat == int'(len));
      check("wstrb", wstrb, 4'hF);
      check("wr_ready", wr_ready, wready);
      check("awvalid_in_w", awvalid, 1'b0);
      if (beat == abort_beat) begin
        areset = 1'b1;
        #1;
        check("rst_wvalid", wvalid, 1'b0);
        check("rst_awvalid", awvalid, 1'b0);
        check("rst_arvalid", arvalid, 1'b0);
        check("rst_bready", bready, 1'b0);
        check("rst_rready", rready, 1'b0);
        check("rst_wr_ready", wr_ready, 1'b0);
        wr_valid = 1'b0;
        wready   = 1'b0;
        repeat (2) @(negedge clk);
        areset = 1'b0;
        @(negedge clk);
        check("cmd_ready_after_rst", cmd_ready, 1'b1);
        check("done_after_rst", done, 1'b0);
        return;
      end
      hs = wready;
      @(posedge clk); #1;
      if (hs) beat++;
      cyc++;
    end
    wr_valid = 1'b0;
    wready   = 1'b0;
    if (cyc >= 100) begin
      check("w_timeout", 1'b0, 1'b1);
      return;
    end
    bvalid = 1'b1;
    bresp  = b_resp;
    @(negedge clk);
    check("bready", bready, 1'b1);
    check("done_before_b", done, 1'b0);
    @(posedge clk); #1;
    bvalid = 1'b0;
    @(negedge clk);
    check("w_done", done, 1'b1);
    check("w_done_resp", done_resp, b_resp);
    check("w_done_err", done_err, 1'b0);
    check("w_cmd_ready", cmd_ready, 1'b1);
    check("bready_off", bready, 1'b0);
    @(negedge clk);
    check("w_done_pulse", done, 1'b0);
  endtask

  // Slave returns beats 0..rlast_at, RLAST on rlast_at; beat err_beat answers SLVERR.
  task automatic do_read(input logic [31:0] addr, input logic [7:0] len, input int rlast_at,
                         input int err_beat, input logic [1:0] exp_resp, input logic exp_err);
    send_cmd(1'b0, addr, len);
    @(negedge clk);
    check("arvalid", arvalid, 1'b1);
    check("araddr", araddr, addr & ~32'h3);
    check("arlen", arlen, len);
    check("arsize", arsize, 3'd2);
    check("arburst", arburst, 2'b01);
    check("awvalid_in_read", awvalid, 1'b0);
    arready = 1'b1;
    @(posedge clk); #1;
    arready = 1'b0;
    for (int b = 0; b <= rlast_at; b++) begin
      rvalid   = 1'b1;
      rdata    = 32'hA000 + 32'(b);
      rlast    = (b == rlast_at);
      rresp    = (b == err_beat) ? 2'b10 : 2'b00;
      rd_ready = 1'b1;
      @(negedge clk);
      check("rd_valid", rd_valid, 1'b1);
      check("rd_data", rd_data, 32'hA000 + 32'(b));
      check("rd_last", rd_last, b == rlast_at);
      check("rready", rready, 1'b1);
      check("arvalid_in_r", arvalid, 1'b0);
      check("done_mid_read", done, 1'b0);
      @(posedge clk); #1;
    end
    rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00; rd_ready = 1'b0;
    @(negedge clk);
    check("r_done", done, 1'b1);
    check("r_done_resp", done_resp, exp_resp);
    check("r_done_err", done_err, exp_err);
    check("r_cmd_ready", cmd_ready, 1'b1);
    check("rready_off", rready, 1'b0);
    @(negedge clk);
    check("r_done_pulse", done, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    areset = 1'b1;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
    wr_data = '0; wr_valid = 1'b0; rd_ready = 1'b0;
    awready = 1'b0; wready = 1'b0; bresp = 2'b00; bvalid = 1'b0;
    arready = 1'b0; rdata = '0; rresp = 2'b00; rlast = 1'b0; rvalid = 1'b0;

    #3;
    check("rst_awvalid0", awvalid, 1'b0);
    check("rst_wvalid0", wvalid, 1'b0);
    check("rst_arvalid0", arvalid, 1'b0);
    check("rst_bready0", bready, 1'b0);
    check("rst_rready0", rready, 1'b0);
    check("rst_cmd_ready0", cmd_ready, 1'b0);
    check("rst_done0", done, 1'b0);
    check("rst_done_resp0", done_resp, 2'b00);
    check("rst_done_err0", done_err, 1'b0);
    check("rst_awaddr0", awaddr, 32'h0);
    check("rst_awlen0", awlen, 8'h0);
    repeat (2) @(negedge clk);
    areset = 1'b0;
    @(negedge clk);
    check("idle_cmd_ready", cmd_ready, 1'b1);

    do_write(32'h100, 8'd3, 0, 1'b0, 2'b00, 32'h1, -1);
    do_read(32'h200, 8'd0, 0, 0, 2'b10, 1'b0);
    do_write(32'h302, 8'd2, 5, 1'b1, 2'b00, 32'h55, -1);
    do_read(32'h400, 8'd3, 2, -1, 2'b00, 1'b1);
    do_read(32'h700, 8'd3, 3, 1, 2'b10, 1'b0);

    // 0xFF8 + 4*4 = 0x1008 runs past the 4KB page.
    send_cmd(1'b1, 32'hFF8, 8'd3);
    @(negedge clk);
    check("rej_awvalid", awvalid, 1'b0);
    check("rej_arvalid", arvalid, 1'b0);
    check("rej_done_early", done, 1'b0);
    check("rej_cmd_ready_busy", cmd_ready, 1'b0);
    @(negedge clk);
    check("rej_done", done, 1'b1);
    check("rej_resp", done_resp, 2'b10);
    check("rej_awvalid2", awvalid, 1'b0);
    check("rej_cmd_ready", cmd_ready, 1'b1);
    @(negedge clk);
    check("rej_done_pulse", done, 1'b0);

    // 0xFF0 + 16 lands exactly on 0x1000: allowed.
    do_write(32'hFF0, 8'd3, 1, 1'b0, 2'b10, 32'h900, -1);
    do_write(32'h500, 8'd3, 0, 1'b0, 2'b00, 32'h10, 2);
    do_write(32'h600, 8'd1, 0, 1'b1, 2'b00, 32'h20, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
